wb_keypad_scan: RTL and testbench
=================================

Name: wb_keypad_scan

Overview:
Parametrised Wishbone matrix-keypad controller for the SoC peripheral space.
- Scans a ROWS x COLS key matrix and debounces whole-matrix snapshots.
- Encodes press events into a FIFO; the CPU pops them through a data register and can take an interrupt.
- Adds what the fixed 4x4 single-key interface lacks: configurable matrix size and scan timing, multi-key detection, buffered events, overflow reporting and an interrupt enable.

Parameters:
- ROWS, 4, number of row inputs (2..8).
- COLS, 4, number of column outputs (2..8).
- SCAN_DIV, 5000, clock cycles each column is driven (>=4).
- DEBOUNCE_SCANS, 4, consecutive identical full-matrix snapshots needed to accept a new stable state (>=1).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..64).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_ack_o  out  1  Wishbone acknowledge.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  32  Wishbone byte address; only [3:2] decoded.
- wb_sel_i  in  4  byte selects; writes take effect only with sel[0]=1.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; bits [31:8] always 0.
- intr  out  1  level interrupt to the CPU.
- kb_column  out  COLS  column drives, active-low, one-hot-low while scanning.
- kb_row  in  ROWS  row sense inputs, active-low with external pull-ups, asynchronous.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset: kb_column = all ones except bit0=0, scan at column 0, slot counter 0, snapshot/stable/reported masks 0, debounce count 0, FIFO empty, overflow 0, irq_en 0, wb_ack_o 0, wb_dat_o 0, intr 0. Reset asserted mid-scan or mid-bus-cycle aborts everything; any pending ack is dropped.
- Input sync: kb_row passes through a 2-flop synchroniser and is inverted (pressed=1).
- Scan: a slot counter runs 0..SCAN_DIV-1 per column. Rows are sampled into snapshot bits [col*ROWS +: ROWS] on slot count SCAN_DIV-1. The column index then advances and wraps COLS-1 -> 0.
- Debounce: at each scan wrap, compare the snapshot with the previous snapshot.
  - Equal: count increments, saturating at DEBOUNCE_SCANS.
  - Different: count resets to 1.
  - When count reaches DEBOUNCE_SCANS, stable <= snapshot.
- Event engine: runs every cycle, at most 1 event per cycle.
  - pend = stable & ~reported. Take its lowest set index k: push code k and set reported[k].
  - Bits in reported whose stable bit is 0 are cleared (release).
  - Code k = col*ROWS + row.
  - FIFO entry is 8 bits: {rel, code[6:0]}; rel=0 for presses.
- Latency bound: a key held stable produces its FIFO entry within (DEBOUNCE_SCANS+2)*COLS*SCAN_DIV + ROWS*COLS + 4 cycles.
- FIFO:
  - Push when full drops the event and sets sticky overflow. reported[k] is still set, so a held key never repeats.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Pop when empty: no state change; reads return 0.
- Wishbone:
  - ack <= stb&cyc&~ack, giving a registered 1-cycle ack. wb_ack_o = stb & cyc & ack.
  - wb_dat_o and side effects are updated on the cycle ack is registered.
  - Back-to-back accesses therefore take 2 cycles each.
- Register map (adr[3:2]):
  - 00 KEY_SR (RO): [0] not_empty, [1] overflow, [2] full, [7:3] 0.
  - 01 KEY_DATA (RO): returns the FIFO head and pops it. Empty returns 0x00.
  - 10 KEY_CR (RW): [0] irq_en. Writing 1 to [1] clears overflow (self-clearing, reads 0).
  - 11: reads 0, writes ignored.
- intr = irq_en & (not_empty | overflow), registered (1-cycle lag).

Optional Feature:
KEY_RELEASE_EN
- Defined: when stable[k] falls while reported[k]=1, the engine pushes {1'b1, code k} before clearing reported[k]. Presses take priority over releases in the same cycle.
- Undefined: releases only clear reported bits; no release entries are ever pushed; bit7 of KEY_DATA is always 0.

Test Plan:
All tests use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
- Reset, then hold no key: kb_column cycles 1110,1101,1011,0111 every 4 clocks; KEY_SR reads 0x00; intr=0.
- Hold row1 low while column2 is driven, for 5 scans: exactly one entry; KEY_SR=0x01; KEY_DATA=0x09; next KEY_SR=0x00.
- Row glitch of 1 scan: no entry. Contact bouncing each scan for 4 scans, then stable: exactly one entry.
- Press keys 0, 5, 10 together: entries 0x00, 0x05, 0x0A, in that order.
- 5 distinct presses without reading: KEY_SR=0x07 and first 4 codes retained. Write KEY_CR=0x02 -> KEY_SR=0x05.
- With irq_en=1, press key 3: intr rises. Read KEY_DATA=0x03 -> intr falls within 2 cycles. With KEY_RELEASE_EN, releasing key 3 yields 0x83. Assert reset mid-press: FIFO empty, no spurious entry.

Source files
------------

// File: rtl/wb_keypad_scan.sv
// wb_keypad_scan: Wishbone matrix-keypad controller.
//   Scans a ROWS x COLS key matrix one active-low column at a time and
//   debounces whole-matrix snapshots. Each newly stable press is queued as an
//   8-bit {rel, code} event. The CPU pops events through KEY_DATA, and a
//   level interrupt can be enabled.
// Build option: define KEY_RELEASE_EN to also queue release events
//   ({1'b1, code}). Without it, releases only re-arm the key.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   wb_*                Wishbone slave with a registered single-cycle ack;
//                       wb_adr_i[3:2] selects KEY_SR / KEY_DATA / KEY_CR / -
//   intr                registered level interrupt
//   kb_column [COLS]    active-low column drives, one low at a time
//   kb_row    [ROWS]    active-low row senses (asynchronous, pulled up)
module wb_keypad_scan #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 5000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_stb_i,
   input  logic            wb_cyc_i,
   output logic            wb_ack_o,
   input  logic            wb_we_i,
   input  logic [31:0]     wb_adr_i,
   input  logic [3:0]      wb_sel_i,
   input  logic [31:0]     wb_dat_i,
   output logic [31:0]     wb_dat_o,
   output logic            intr,
   output logic [COLS-1:0] kb_column,
   input  logic [ROWS-1:0] kb_row
);

   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(COLS);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_SCANS);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   // ---------------- scan and debounce ----------------
   logic [ROWS-1:0] row_s1, row_s2;
   logic [SW-1:0]   slot;
   logic [CW-1:0]   col, col_nx;
   logic [N-1:0]    snapshot, prev_snap, stable, snap_nx;
   logic [DW-1:0]   deb_cnt, deb_nx;
   logic            slot_end, wrap;

   assign slot_end = (slot == SLOT_LAST);
   assign wrap     = slot_end && (col == COL_LAST);
   assign col_nx   = wrap ? '0 : col + 1'b1;

   // Snapshot including the current column's rows. It is used directly at the
   // wrap, so the last column is already part of the comparison.
   always_comb begin
      snap_nx = snapshot;
      snap_nx[int'(col) * ROWS +: ROWS] = ~row_s2;
   end

   always_comb begin
      if (snap_nx == prev_snap)
         deb_nx = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
      else
         deb_nx = DW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_s1    <= '1;
         row_s2    <= '1;
         slot      <= '0;
         col       <= '0;
         kb_column <= ~COLS'(1);
         snapshot  <= '0;
         prev_snap <= '0;
         stable    <= '0;
         deb_cnt   <= '0;
      end else begin
         row_s1 <= kb_row;
         row_s2 <= row_s1;
         if (slot_end) begin
            slot      <= '0;
            col       <= col_nx;
            kb_column <= ~(COLS'(1) << col_nx);
            snapshot  <= snap_nx;
            if (wrap) begin
               prev_snap <= snap_nx;
               deb_cnt   <= deb_nx;
               if (deb_nx == DEB_MAX)
                  stable <= snap_nx;
            end
         end else begin
            slot <= slot + 1'b1;
         end
      end
   end

   // ---------------- event engine ----------------
   logic [N-1:0] reported, reported_nx, pend;
   logic         press_hit;
   logic [6:0]   press_code;
   logic         ev_push;
   logic [7:0]   ev_data;

   assign pend = stable & ~reported;

   always_comb begin
      press_hit  = 1'b0;
      press_code = '0;
      for (int unsigned i = 0; i < N; i++)
         if (!press_hit && pend[i]) begin
            press_hit  = 1'b1;
            press_code = 7'(i);
         end
   end

`ifdef KEY_RELEASE_EN
   logic [N-1:0] gone;
   logic         rel_hit;
   logic [6:0]   rel_code;

   assign gone = reported & ~stable;

   always_comb begin
      rel_hit  = 1'b0;
      rel_code = '0;
      for (int unsigned i = 0; i < N; i++)
         if (!rel_hit && gone[i]) begin
            rel_hit  = 1'b1;
            rel_code = 7'(i);
         end
   end

   // Released keys stay reported until their event goes out; presses win.
   always_comb begin
      ev_push     = 1'b0;
      ev_data     = '0;
      reported_nx = reported;
      if (press_hit) begin
         ev_push     = 1'b1;
         ev_data     = {1'b0, press_code};
         reported_nx = reported | (N'(1) << press_code);
      end else if (rel_hit) begin
         ev_push     = 1'b1;
         ev_data     = {1'b1, rel_code};
         reported_nx = reported & ~(N'(1) << rel_code);
      end
   end
`else
   always_comb begin
      ev_push     = press_hit;
      ev_data     = {1'b0, press_code};
      reported_nx = reported & stable;
      if (press_hit)
         reported_nx = reported_nx | (N'(1) << press_code);
   end
`endif

   // ---------------- FIFO and Wishbone ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          full, not_empty, overflow, irq_en, ack;
   logic          acc, rd_acc, wr_acc, cr_wr, pop, push_ok, ovf_set;
   logic [7:0]    rdata, dat_r;
   logic          unused_bits;

   assign full      = (cnt == FULL_CNT);
   assign not_empty = (cnt != '0);

   assign acc     = wb_stb_i & wb_cyc_i & ~ack;
   assign rd_acc  = acc & ~wb_we_i;
   assign wr_acc  = acc & wb_we_i & wb_sel_i[0];
   assign cr_wr   = wr_acc & (wb_adr_i[3:2] == 2'b10);
   assign pop     = rd_acc & (wb_adr_i[3:2] == 2'b01) & not_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = ev_push & (~full | pop);
   assign ovf_set = ev_push & full & ~pop;

   always_comb begin
      rdata = '0;
      case (wb_adr_i[3:2])
         2'b00:   rdata = {5'b0, full, overflow, not_empty};
         2'b01:   rdata = not_empty ? mem[rd_ptr] : 8'h00;
         2'b10:   rdata = {7'b0, irq_en};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk)
      if (push_ok)
         mem[wr_ptr] <= ev_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         reported <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
         irq_en   <= 1'b0;
         ack      <= 1'b0;
         dat_r    <= '0;
         intr     <= 1'b0;
      end else begin
         reported <= reported_nx;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         // A drop in the same cycle as a clear is still reported.
         if (ovf_set)
            overflow <= 1'b1;
         else if (cr_wr && wb_dat_i[1])
            overflow <= 1'b0;
         if (cr_wr)
            irq_en <= wb_dat_i[0];
         ack <= wb_stb_i & wb_cyc_i & ~ack;
         if (rd_acc)
            dat_r <= rdata;
         else if (acc)
            dat_r <= '0;
         intr <= irq_en & (not_empty | overflow);
      end
   end

   assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack;
   assign wb_dat_o    = {24'h0, dat_r};
   assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:2], wb_sel_i[3:1]};

endmodule

// File: tb/tb_wb_keypad_scan.sv
// tb_wb_keypad_scan: self-checking bench for wb_keypad_scan.
//   Configuration: 4x4 matrix, SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
//   A behavioural keypad pulls a row low when its key is held and the key's
//   column is driven low. Expected read data is queued when a read is issued
//   and compared when the ack arrives.
module tb_wb_keypad_scan;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_stb_i, wb_cyc_i, wb_ack_o, wb_we_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        intr;
   logic [3:0]  kb_column;
   logic [3:0]  kb_row;
   logic [15:0] keys;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic       we;
      logic [1:0] adr;
      logic [3:0] sel;
      logic [7:0] wdat;
      logic [7:0] exp;
   } bus_vec_t;

   bus_vec_t   ovf_tab [16];
   logic [3:0] col_tab [16];

   wb_keypad_scan #(
      .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
      .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
      .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .intr(intr),
      .kb_column(kb_column), .kb_row(kb_row)
   );

   always #5 clk = ~clk;

   // Key code = col*4 + row.
   always_comb begin
      kb_row = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kb_column[c] && keys[c*4 + r])
               kb_row[r] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb_rd(input logic [1:0] adr, input logic [7:0] exp, input string name);
      logic got;
      exp_q.push_back({24'h0, exp});
      wb_adr_i = {28'h0, adr, 2'b00};
      wb_we_i  = 1'b0;
      wb_sel_i = 4'hF;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o) got = 1'b1;
      end
      if (got) begin
         chk(name, wb_dat_o, exp_q.pop_front());
      end else begin
         void'(exp_q.pop_front());
         checks++;
         errors++;
         $display("FAIL %s: no ack within 8 cycles, required ack=1", name);
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      idle(1);
   endtask

   task automatic wb_wr(input logic [1:0] adr, input logic [7:0] dat, input logic [3:0] sel,
                        input string name);
      logic got;
      wb_adr_i = {28'h0, adr, 2'b00};
      wb_we_i  = 1'b1;
      wb_sel_i = sel;
      wb_dat_i = {24'h0, dat};
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: no ack within 8 cycles, required ack=1", name);
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      idle(1);
   endtask

   task automatic do_reset();
      keys  = '0;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;

      col_tab = '{4'b1110, 4'b1110, 4'b1110,
                  4'b1101, 4'b1101, 4'b1101, 4'b1101,
                  4'b1011, 4'b1011, 4'b1011, 4'b1011,
                  4'b0111, 4'b0111, 4'b0111, 4'b0111,
                  4'b1110};

      // After 5 simultaneous presses (codes 1,2,3,4,7) into a 4-entry FIFO.
      ovf_tab[0]  = '{1'b0, 2'd0, 4'hF, 8'h00, 8'h07};
      ovf_tab[1]  = '{1'b1, 2'd2, 4'hE, 8'h01, 8'h00}; // sel[0]=0: ignored
      ovf_tab[2]  = '{1'b0, 2'd2, 4'hF, 8'h00, 8'h00};
      ovf_tab[3]  = '{1'b1, 2'd2, 4'h1, 8'h02, 8'h00}; // clear overflow
      ovf_tab[4]  = '{1'b0, 2'd0, 4'hF, 8'h00, 8'h05};
      ovf_tab[5]  = '{1'b0, 2'd2, 4'hF, 8'h00, 8'h00};
      ovf_tab[6]  = '{1'b0, 2'd1, 4'hF, 8'h00, 8'h01};
      ovf_tab[7]  = '{1'b0, 2'd1, 4'hF, 8'h00, 8'h02};
      ovf_tab[8]  = '{1'b0, 2'd0, 4'hF, 8'h00, 8'h01};
      ovf_tab[9]  = '{1'b0, 2'd1, 4'hF, 8'h00, 8'h03};
      ovf_tab[10] = '{1'b0, 2'd1, 4'hF, 8'h00, 8'h04};
      ovf_tab[11] = '{1'b0, 2'd0, 4'hF, 8'h00, 8'h00};
      ovf_tab[12] = '{1'b0, 2'd1, 4'hF, 8'h00, 8'h00}; // empty pop
      ovf_tab[13] = '{1'b1, 2'd3, 4'hF, 8'hFF, 8'h00};
      ovf_tab[14] = '{1'b0, 2'd3, 4'hF, 8'h00, 8'h00};
      ovf_tab[15] = '{1'b0, 2'd0, 4'hF, 8'h00, 8'h00};

      reset    = 1'b1;
      keys     = '0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_adr_i = '0;
      wb_sel_i = '0;
      wb_dat_i = '0;

      // Reset state
      idle(3);
      chk("rst_column", {28'h0, kb_column}, 32'hE);
      chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      chk("rst_intr", {31'h0, intr}, 32'h0);
      reset = 1'b0;

      // Column scan sequence
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("col[%0d]", k + 1), {28'h0, kb_column}, {28'h0, col_tab[k]});
      end
      wb_rd(2'd0, 8'h00, "idle_sr");
      wb_rd(2'd2, 8'h00, "idle_cr");
      chk("idle_intr", {31'h0, intr}, 32'h0);

      // Single key: row1 in column2 -> code 9
      keys[9] = 1'b1;
      idle(96);
      wb_rd(2'd0, 8'h01, "k9_sr");
      wb_rd(2'd1, 8'h09, "k9_data");
      wb_rd(2'd0, 8'h00, "k9_sr_after");

      // One-scan glitch produces nothing
      do_reset();
      keys[6] = 1'b1;
      idle(16);
      keys[6] = 1'b0;
      idle(96);
      wb_rd(2'd0, 8'h00, "glitch_sr");

      // Bouncing contact, then stable: exactly one entry
      do_reset();
      for (int i = 0; i < 2; i++) begin
         keys[6] = 1'b1;
         idle(16);
         keys[6] = 1'b0;
         idle(16);
      end
      keys[6] = 1'b1;
      idle(96);
      wb_rd(2'd0, 8'h01, "bounce_sr");
      wb_rd(2'd1, 8'h06, "bounce_data");
      wb_rd(2'd0, 8'h00, "bounce_sr_after");

      // Multi-key: lowest code first
      do_reset();
      keys = 16'h0421;
      idle(96);
      wb_rd(2'd0, 8'h01, "multi_sr");
      wb_rd(2'd1, 8'h00, "multi_d0");
      wb_rd(2'd1, 8'h05, "multi_d1");
      wb_rd(2'd1, 8'h0A, "multi_d2");
      wb_rd(2'd0, 8'h00, "multi_sr_after");

      // Overflow: 5 presses into 4 entries, then table of accesses
      do_reset();
      keys = 16'h009E;
      idle(96);
      for (int i = 0; i < 16; i++) begin
         if (ovf_tab[i].we)
            wb_wr(ovf_tab[i].adr, ovf_tab[i].wdat, ovf_tab[i].sel, $sformatf("ovf_wr[%0d]", i));
         else
            wb_rd(ovf_tab[i].adr, ovf_tab[i].exp, $sformatf("ovf_rd[%0d]", i));
      end
      chk("ovf_intr", {31'h0, intr}, 32'h0);

      // Interrupt
      do_reset();
      wb_wr(2'd2, 8'h01, 4'h1, "irq_en_wr");
      wb_rd(2'd2, 8'h01, "irq_en_rd");
      chk("irq_idle", {31'h0, intr}, 32'h0);
      keys[3] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 150 && !got; i++) begin
         @(posedge clk);
         #1;
         if (intr) got = 1'b1;
      end
      chk("irq_rise", {31'h0, intr}, 32'h1);
      wb_rd(2'd1, 8'h03, "irq_data");
      got = 1'b0;
      for (int i = 0; i < 2 && !got; i++) begin
         if (!intr) got = 1'b1;
         else idle(1);
      end
      chk("irq_fall", {31'h0, intr}, 32'h0);
      keys[3] = 1'b0;
      idle(96);
`ifdef KEY_RELEASE_EN
      wb_rd(2'd1, 8'h83, "release_data");
`endif
      wb_rd(2'd0, 8'h00, "release_sr");
      chk("release_intr", {31'h0, intr}, 32'h0);

      // Reset mid-press and mid-bus-cycle
      keys[12] = 1'b1;
      idle(40);
      reset    = 1'b1;
      wb_adr_i = 32'h0;
      wb_we_i  = 1'b0;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      idle(1);
      chk("rst_bus_ack", {31'h0, wb_ack_o}, 32'h0);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      keys     = '0;
      idle(1);
      reset = 1'b0;
      idle(96);
      wb_rd(2'd0, 8'h00, "rst_press_sr");
      wb_rd(2'd1, 8'h00, "rst_press_data");
      chk("rst_press_intr", {31'h0, intr}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
